// File: rtl/sc_stream_decoder_if.sv
// Stream-decoder bus: sample inputs (start/enable/inBit) and result outputs.
// state_dbg mirrors the FSM (1 = ACC) so checkers can bind to it.
interface sc_stream_decoder_if #(
  parameter int WINL2 = 8
);
  // Handshake: start is taken only while busy is low (a done cycle counts as
  // idle); inBit is sampled only when enable is high; done pulses for one
  // cycle and result holds its value until the next done.
  logic             start;
  logic             enable;
  logic             inBit;
  logic             busy;
  logic             done;
  logic [WINL2:0]   result;
  logic             state_dbg;

  modport master (
    output start, enable, inBit,
    input  busy, done, result, state_dbg
  );

  modport slave (
    input  start, enable, inBit,
    output busy, done, result, state_dbg
  );
endinterface

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts 1s over 2^WINL2 enabled bits.
// Define SC_DEC_BIPOLAR_EN for a signed bipolar result (acc - 2^(WINL2-1)).
module sc_stream_decoder #(
  parameter int RWID  = 8,
  parameter int WINL2 = RWID
) (
  input  logic                 clk,
  input  logic                 rst,
  sc_stream_decoder_if.slave   bus
);
  localparam int unsigned    WIN  = 1 << WINL2;
  localparam logic [WINL2:0] LAST = (WINL2 + 1)'(WIN - 1);
  localparam logic [WINL2:0] HALF = (WINL2 + 1)'(WIN / 2);

  typedef enum logic {IDLE, ACC} state_t;

  state_t          state;
  logic [WINL2:0]  acc;
  logic [WINL2:0]  win_cnt;
  logic [WINL2:0]  acc_next;
  logic [WINL2:0]  result_next;
  logic            busy_r;
  logic            done_r;
  logic [WINL2:0]  result_r;

  always_comb begin
    acc_next = acc + {{WINL2{1'b0}}, bus.inBit};
`ifdef SC_DEC_BIPOLAR_EN
    result_next = acc_next - HALF;
`else
    result_next = acc_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      acc      <= '0;
      win_cnt  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          // The start cycle is also the first sample of the window.
          if (bus.start) begin
            acc     <= {{WINL2{1'b0}}, bus.inBit & bus.enable};
            win_cnt <= {{WINL2{1'b0}}, bus.enable};
            busy_r  <= 1'b1;
            state   <= ACC;
          end
        end
        ACC: begin
          if (bus.enable) begin
            acc     <= acc_next;
            win_cnt <= win_cnt + 1'b1;
            if (win_cnt == LAST) begin
              result_r <= result_next;
              done_r   <= 1'b1;
              busy_r   <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.result    = result_r;
  assign bus.state_dbg = (state == ACC);
endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed bench for sc_stream_decoder with WINL2=3 (8-bit windows).
// Expected results follow SC_DEC_BIPOLAR_EN when the macro is defined.
module tb_sc_stream_decoder;
  localparam int WINL2 = 3;

  logic clk;
  logic rst;
  int   n_vec  = 0;
  int   n_miss = 0;

  sc_stream_decoder_if #(.WINL2(WINL2)) bus ();

  sc_stream_decoder #(.RWID(8), .WINL2(WINL2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [WINL2:0] exp_res(input int ones);
`ifdef SC_DEC_BIPOLAR_EN
    return (WINL2 + 1)'(ones - 4);
`else
    return (WINL2 + 1)'(ones);
`endif
  endfunction

  // Apply one cycle of inputs; returns 1 time unit after the capturing edge.
  task automatic drive(input logic s, input logic e, input logic b);
    bus.start  = s;
    bus.enable = e;
    bus.inBit  = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.enable = 1'b0; bus.inBit = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0 || bus.state_dbg !== 1'b0) begin
      n_miss++;
      $display("FAIL reset: busy=%b done=%b result=%h state=%b, need 0/0/0/0",
               bus.busy, bus.done, bus.result, bus.state_dbg);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_idle_hold();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state_dbg !== 1'b0) begin
        n_miss++;
        $display("FAIL idle_hold[%0d]: busy=%b done=%b state=%b, need 0/0/0",
                 i, bus.busy, bus.done, bus.state_dbg);
      end
    end
  endtask

  task automatic test_all_ones();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 8; c++) begin
      n_vec++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        n_miss++;
        $display("FAIL ones_busy[c%0d]: busy=%b done=%b, need 1/0", c, bus.busy, bus.done);
      end
      drive(1'b0, 1'b1, 1'b1);
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.result !== exp_res(8)) begin
      n_miss++;
      $display("FAIL ones_done: done=%b busy=%b result=%h, need 1/0/%h",
               bus.done, bus.busy, bus.result, exp_res(8));
    end
    drive(1'b0, 1'b1, 1'b0);
    n_vec++;
    if (bus.done !== 1'b0 || bus.result !== exp_res(8)) begin
      n_miss++;
      $display("FAIL ones_hold: done=%b result=%h, need 0/%h", bus.done, bus.result, exp_res(8));
    end
  endtask

  task automatic test_all_zeros();
    drive(1'b1, 1'b1, 1'b0);
    for (int c = 1; c < 8; c++) begin
      n_vec++;
      if (bus.done !== 1'b0 || bus.result !== exp_res(8)) begin
        n_miss++;
        $display("FAIL zeros_early[c%0d]: done=%b result=%h, need 0/%h",
                 c, bus.done, bus.result, exp_res(8));
      end
      drive(1'b0, 1'b1, 1'b0);
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.result !== exp_res(0)) begin
      n_miss++;
      $display("FAIL zeros_done: done=%b result=%h, need 1/%h", bus.done, bus.result, exp_res(0));
    end
  endtask

  task automatic test_enable_gaps();
    logic en_v  [11] = '{1,1,0,0,0,1,1,1,1,1,1};
    logic bit_v [11] = '{1,0,1,1,1,1,0,1,0,1,0};
    for (int c = 0; c < 11; c++) begin
      drive(c == 0, en_v[c], bit_v[c]);
      n_vec++;
      if (c < 10 && (bus.done !== 1'b0 || bus.busy !== 1'b1)) begin
        n_miss++;
        $display("FAIL gaps_early[c%0d]: done=%b busy=%b, need 0/1", c + 1, bus.done, bus.busy);
      end else if (c == 10 && (bus.done !== 1'b1 || bus.result !== exp_res(4))) begin
        n_miss++;
        $display("FAIL gaps_done: done=%b result=%h, need 1/%h", bus.done, bus.result, exp_res(4));
      end
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 8; c++) drive(c == 3, 1'b1, 1'b1);
    n_vec++;
    if (bus.done !== 1'b1 || bus.result !== exp_res(8)) begin
      n_miss++;
      $display("FAIL b2b_first: done=%b result=%h, need 1/%h", bus.done, bus.result, exp_res(8));
    end
    // Start in the done cycle; it is also the first sample of window two.
    drive(1'b1, 1'b1, 1'b1);
    n_vec++;
    if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.result !== exp_res(8)) begin
      n_miss++;
      $display("FAIL b2b_restart: busy=%b done=%b result=%h, need 1/0/%h",
               bus.busy, bus.done, bus.result, exp_res(8));
    end
    for (int c = 1; c < 8; c++) drive(1'b0, 1'b1, c < 3);
    n_vec++;
    if (bus.done !== 1'b1 || bus.result !== exp_res(3)) begin
      n_miss++;
      $display("FAIL b2b_second: done=%b result=%h, need 1/%h", bus.done, bus.result, exp_res(3));
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 5; c++) drive(1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    n_vec++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== '0) begin
      n_miss++;
      $display("FAIL reset_mid: busy=%b done=%b result=%h, need 0/0/0",
               bus.busy, bus.done, bus.result);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 1'b1, 1'b1);
    for (int c = 1; c < 8; c++) begin
      n_vec++;
      if (bus.done !== 1'b0) begin
        n_miss++;
        $display("FAIL reset_mid_early[c%0d]: done=%b, need 0", c, bus.done);
      end
      drive(1'b0, 1'b1, 1'b1);
    end
    n_vec++;
    if (bus.done !== 1'b1 || bus.result !== exp_res(8)) begin
      n_miss++;
      $display("FAIL reset_mid_after: done=%b result=%h, need 1/%h",
               bus.done, bus.result, exp_res(8));
    end
  endtask

  initial begin
    test_reset();
    test_idle_hold();
    test_all_ones();
    test_all_zeros();
    test_enable_gaps();
    test_back_to_back();
    test_reset_mid();
    drive(1'b0, 1'b0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/sc_stream_decoder.md
# sc_stream_decoder

Stochastic-to-binary decoder: it counts the 1s of a unary bitstream over a window of 2^WINL2 enabled bits and returns the count as a binary result. It is the receiving end of the Sobol-based stochastic number generators, and it turns stochastic-computing outputs back into binary for downstream logic or scoreboards. The `enable` qualifier matches the generator's, so one shared enable keeps encoder and decoder windows aligned.

## Interface
- `RWID`, default 8: generator width this decoder pairs with.
- `WINL2`, default `RWID`: log2 of the window length in enabled bits; legal range 1..16.
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `start`, input, 1: starts a window; accepted only while idle.
- `enable`, input, 1: `inBit` is valid this cycle.
- `inBit`, input, 1: stochastic bitstream input.
- `busy`, output, 1: a window is in progress.
- `done`, output, 1: one-cycle pulse; `result` was updated.
- `result`, output, WINL2+1: decoded value, held until the next `done`.

## Operation
- Two-state FSM: IDLE and ACC.
- **IDLE, `start`=1:**
  - The start cycle is the first sample cycle: `acc` <= `inBit & enable`; `winCnt` <= `enable`.
  - Next state is ACC.
- **IDLE, `start`=0:** the block holds; `inBit` and `enable` are ignored.
- **ACC, `enable`=1:**
  - `acc` += `inBit`; `winCnt` += 1.
  - The last bit of the window is the cycle where `winCnt` reaches 2^WINL2 as seen on this edge, i.e. `winCnt` = 2^WINL2−1 before the edge.
  - On that edge `result` is loaded from the final `acc`, `done` is set, and the next state is IDLE.
- **ACC, `enable`=0:** no sample is taken and counters hold. Gaps of any length are allowed.
- **`start` during ACC:** ignored, with no restart.
- **`start` on a `done` cycle:** the FSM is already IDLE, so the start is accepted. This gives back-to-back windows with no lost bit.
- **Widths:**
  - `acc` and `winCnt` are WINL2+1 bits; `acc` never exceeds 2^WINL2.
  - `winCnt` clears when a window starts.
- **Unipolar result** (default): `result` = number of 1s, range 0..2^WINL2, unsigned.
- **`rst` asserted mid-window:** the window is abandoned immediately and no `done` is produced.

## Timing
- Reset values:
  - state = IDLE, `acc` = 0, `winCnt` = 0.
  - `busy` = 0, `done` = 0, `result` = 0.
- `busy`:
  - Registered; it goes high the cycle after an accepted `start` and stays high while in ACC.
  - It is low in the `done` cycle.
- `done`:
  - Registered; it is high for exactly one cycle, the cycle after the edge that captured the last bit.
- Latency with `enable` held high:
  - If `start` is in cycle 0, the last sample is in cycle 2^WINL2−1 and `done` is high in cycle 2^WINL2.
- `result`:
  - Changes only on the edge that raises `done`; it is stable in every other cycle.
- No combinational paths from inputs to outputs.

## Configuration
- Macro: `SC_DEC_BIPOLAR_EN`.
- **Defined:** `result` is two's-complement signed, `result` = `acc` − 2^(WINL2−1).
  - Range is −2^(WINL2−1)..+2^(WINL2−1), which fits in WINL2+1 bits.
  - This encodes the bipolar value (2·ones−N)/N scaled by N/2.
  - Reset value stays 0.
- **Undefined:** unipolar unsigned count as described in Operation.
- Timing, handshake and FSM are identical in both builds.

## Test plan
All scenarios use WINL2=3 (8-bit window).
- **All ones:** `start`, then 8 cycles of `inBit`=1 with `enable`=1.
  - `done` is high in cycle 8; `result` = 8 unipolar, +4 bipolar.
- **All zeros:** same stimulus with `inBit`=0.
  - `result` = 0 unipolar, −4 (4'b1100) bipolar.
- **Enable gaps:** pattern 1,0,1,0,1,0,1,0 with `enable` low for 3 cycles after the 2nd bit.
  - `done` is high in cycle 11; `result` = 4 unipolar, 0 bipolar.
- **Start while busy, then back-to-back:** `start` pulsed mid-window; then `start` asserted in the `done` cycle of an all-ones window, followed by a second window of 3 ones.
  - The mid-window `start` has no effect: `done` still occurs after 8 enabled bits.
  - The second window's first sample is taken in the `done` cycle; its result is 3.
- **Reset mid-window:** `rst` after 5 bits.
  - `busy`, `done` and `result` are 0 immediately.
  - A fresh `start` with 8 ones gives `result` = 8.
